// File: rtl/dpi_call_arbiter_if.sv
// Handshake bundle for dpi_call_arbiter: requester side plus the shared engine channel.
interface dpi_call_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_arg;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      result;
  logic                  call_valid;
  logic                  call_ready;
  logic [WIDTH-1:0]      call_arg;
  logic [IDW-1:0]        call_id;
  logic                  rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic                  busy;
  logic                  err_timeout;
  logic                  err_spurious;

  modport slave (
    input  req, req_arg, call_ready, rsp_valid, rsp_data,
    output ack, result, call_valid, call_arg, call_id, busy, err_timeout, err_spurious
  );

  modport master (
    output req, req_arg, call_ready, rsp_valid, rsp_data,
    input  ack, result, call_valid, call_arg, call_id, busy, err_timeout, err_spurious
  );
endinterface

// File: rtl/dpi_call_arbiter.sv
// Round-robin arbiter sharing one DPI call channel among NREQ requesters, with watchdog.
// Optional statistics outputs (call_count, max_wait) enabled by defining DPI_ARB_STATS_EN.
module dpi_call_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  dpi_call_arbiter_if.slave    bus
`ifdef DPI_ARB_STATS_EN
  ,
  output logic [31:0]          call_count,
  output logic [15:0]          max_wait
`endif
);
  localparam int IDW = $clog2(NREQ);
  localparam int unsigned N = NREQ;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [31:0]     cnt;
  logic [IDW-1:0]  grant_id;
  logic [WIDTH-1:0] grant_arg;
  logic            found;
  int unsigned     k;
  logic            timeout_hit;

  // First requester strictly after ptr, wrapping around.
  always_comb begin
    grant_id  = '0;
    grant_arg = '0;
    found     = 1'b0;
    k         = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      k = (32'(ptr) + i) % N;
      if (!found && bus.req[IDW'(k)]) begin
        found     = 1'b1;
        grant_id  = IDW'(k);
        grant_arg = bus.req_arg[k*WIDTH +: WIDTH];
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt == 32'(TIMEOUT - 1));

`ifdef DPI_ARB_STATS_EN
  logic [15:0] wait_len;
  // WAIT duration of the call ending this cycle is cnt+1.
  always_comb begin
    wait_len = (cnt >= 32'h0000_FFFF) ? 16'hFFFF : (cnt[15:0] + 16'd1);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      ptr              <= IDW'(NREQ - 1);
      cnt              <= '0;
      bus.ack          <= '0;
      bus.result       <= '0;
      bus.call_valid   <= 1'b0;
      bus.call_arg     <= '0;
      bus.call_id      <= '0;
      bus.busy         <= 1'b0;
      bus.err_timeout  <= 1'b0;
      bus.err_spurious <= 1'b0;
`ifdef DPI_ARB_STATS_EN
      call_count       <= '0;
      max_wait         <= '0;
`endif
    end else begin
      if (bus.rsp_valid && state != S_WAIT) bus.err_spurious <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (found) begin
            bus.call_id    <= grant_id;
            bus.call_arg   <= grant_arg;
            bus.call_valid <= 1'b1;
            bus.busy       <= 1'b1;
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.call_ready) begin
            bus.call_valid <= 1'b0;
            cnt            <= '0;
            state          <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.rsp_valid || timeout_hit) begin
            bus.result <= bus.rsp_valid ? bus.rsp_data : '0;
            if (!bus.rsp_valid) bus.err_timeout <= 1'b1;
            bus.ack    <= NREQ'(1) << bus.call_id;
            state      <= S_DONE;
`ifdef DPI_ARB_STATS_EN
            if (wait_len > max_wait) max_wait <= wait_len;
`endif
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_DONE: begin
          bus.ack  <= '0;
          bus.busy <= 1'b0;
          ptr      <= bus.call_id;
          state    <= S_IDLE;
`ifdef DPI_ARB_STATS_EN
          call_count <= call_count + 32'd1;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
